// File: rtl/avs_to_axs_pixel_gasket.sv
// Avalon-ST to AXI4-Stream pixel bridge: repacks power-of-2 channel slots into tightly
// packed byte-padded pixels and passes them through a registered 2-entry skid stage.
module avs_to_axs_pixel_gasket #(
    parameter int unsigned PARALLEL_PIXELS      = 4,
    parameter int unsigned BITS_PER_CHANNEL     = 10,
    parameter int unsigned CHANNELS             = 4,
    localparam int unsigned BITS_PER_CHANNEL_AV  = 1 << $clog2(BITS_PER_CHANNEL),
    localparam int unsigned BITS_PER_PIXEL_AV    = BITS_PER_CHANNEL_AV * CHANNELS,
    localparam int unsigned BITS_AV              = BITS_PER_PIXEL_AV * PARALLEL_PIXELS,
    localparam int unsigned EMPTY_BITS           = $clog2(BITS_AV / 8),
    localparam int unsigned BITS_PER_CHANNEL_AXI = BITS_PER_CHANNEL,
    localparam int unsigned BITS_PER_PIXEL_AXI   =
        8 * ((CHANNELS * BITS_PER_CHANNEL_AXI + 7) / 8),
    localparam int unsigned BITS_AXI             = BITS_PER_PIXEL_AXI * PARALLEL_PIXELS,
    localparam int unsigned TUSER_BITS           = (BITS_AXI + 7) / 8,
    localparam int unsigned TUSER_FILL           = TUSER_BITS - 2
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset,
    output logic                  asi_ready,
    input  logic                  asi_valid,
    input  logic [BITS_AV-1:0]    asi_data,
    input  logic                  asi_startofpacket,
    input  logic                  asi_endofpacket,
    input  logic [EMPTY_BITS-1:0] asi_empty,
    input  logic                  axm_tready,
    output logic                  axm_tvalid,
    output logic [BITS_AXI-1:0]   axm_tdata,
    output logic                  axm_tlast,
    output logic [TUSER_BITS-1:0] axm_tuser
);

    localparam logic [BITS_PER_CHANNEL_AXI-1:0] MaskOut = '1;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    typedef struct packed {
        logic [BITS_AXI-1:0] data;
        logic                eop;
        logic                sop;
    } beat_t;

    state_e state_q, state_d;
    beat_t  out_q, out_d;
    beat_t  ovf_q, ovf_d;
    logic   ready_q, ready_d;
    beat_t  in_beat;
    logic   accept;
    logic   xfer;

    // Only full beats are carried and the upper slot bits are dropped by design.
    logic unused_avalon;
    assign unused_avalon = ^{asi_empty, asi_data};

    always_comb begin
        in_beat      = '0;
        in_beat.sop  = asi_startofpacket;
        in_beat.eop  = asi_endofpacket;
        for (int p = 0; p < int'(PARALLEL_PIXELS); p++) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                in_beat.data[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL_AXI] =
                    asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL_AXI]
                    & MaskOut;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        accept  = asi_valid & ready_q;
        xfer    = (state_q != StEmpty) & axm_tready;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    out_d   = in_beat;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && !xfer) begin
                    ovf_d   = in_beat;
                    state_d = StFull;
                end else if (xfer && !accept) begin
                    state_d = StEmpty;
                end else if (accept && xfer) begin
                    out_d = in_beat;
                end
            end
            StFull: begin
                if (xfer) begin
                    out_d   = ovf_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Registered so the sink ready has no combinational path from axm_tready.
        ready_d = (state_d != StFull);
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state_q <= StEmpty;
            out_q   <= '0;
            ovf_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
        end
    end

    assign asi_ready  = ready_q;
    assign axm_tvalid = (state_q != StEmpty);
    assign axm_tdata  = out_q.data;
    assign axm_tlast  = out_q.eop;
    assign axm_tuser  = {{TUSER_FILL{1'b0}}, out_q.eop, out_q.sop};

endmodule

// File: tb/tb_avs_to_axs_pixel_gasket.sv
// Directed and randomized self-checking bench for avs_to_axs_pixel_gasket.
module tb_avs_to_axs_pixel_gasket;

    localparam int BAV = 256;
    localparam int BAXI = 160;
    localparam int TUB = 20;

    logic           clk;
    logic           rst;
    logic           asi_ready;
    logic           asi_valid;
    logic [BAV-1:0] asi_data;
    logic           asi_sop;
    logic           asi_eop;
    logic [4:0]     asi_empty;
    logic           axm_tready;
    logic           axm_tvalid;
    logic [BAXI-1:0] axm_tdata;
    logic           axm_tlast;
    logic [TUB-1:0] axm_tuser;

    int pass_cnt = 0;
    int check_cnt = 0;

    typedef struct packed {
        logic [BAXI-1:0] data;
        logic            eop;
        logic            sop;
    } exp_t;

    exp_t sb[$];

    avs_to_axs_pixel_gasket dut (
        .csi_clk           (clk),
        .rsi_reset         (rst),
        .asi_ready         (asi_ready),
        .asi_valid         (asi_valid),
        .asi_data          (asi_data),
        .asi_startofpacket (asi_sop),
        .asi_endofpacket   (asi_eop),
        .asi_empty         (asi_empty),
        .axm_tready        (axm_tready),
        .axm_tvalid        (axm_tvalid),
        .axm_tdata         (axm_tdata),
        .axm_tlast         (axm_tlast),
        .axm_tuser         (axm_tuser)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [BAXI-1:0] repack(input logic [BAV-1:0] d);
        logic [BAXI-1:0] r;
        r = '0;
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++)
                r[p*40 + c*10 +: 10] = d[p*64 + c*16 +: 10];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [BAV-1:0] pat;
    logic [BAV-1:0] beat_a;
    logic [BAV-1:0] beat_b;
    logic [BAV-1:0] beat_c;
    logic [BAV-1:0] rnd;
    logic [39:0]    pix0_exp;
    logic [9:0]     p3c3_exp;
    exp_t           front;
    int             sent;
    int             cycles;
    logic           acc;
    logic           xfr;

    initial begin
        rst        = 1'b1;
        asi_valid  = 1'b0;
        asi_data   = '0;
        asi_sop    = 1'b0;
        asi_eop    = 1'b0;
        asi_empty  = '0;
        axm_tready = 1'b0;

        repeat (3) tick();
        chk("rst_tvalid", 256'(axm_tvalid), 256'd0);
        chk("rst_tdata", 256'(axm_tdata), 256'd0);
        chk("rst_tuser", 256'(axm_tuser), 256'd0);
        chk("rst_tlast", 256'(axm_tlast), 256'd0);
        chk("rst_ready", 256'(asi_ready), 256'd0);

        rst = 1'b0;
        tick();
        chk("post_rst_ready", 256'(asi_ready), 256'd1);
        chk("post_rst_tvalid", 256'(axm_tvalid), 256'd0);

        // Channel (p,c) carries 16*(p+1)+(c+1).
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++)
                pat[p*64 + c*16 +: 16] = 16'(16*(p+1) + (c+1));
        pix0_exp   = 40'h0501304811;
        p3c3_exp   = 10'h044;
        asi_data   = pat;
        asi_valid  = 1'b1;
        axm_tready = 1'b1;
        tick();
        chk("repack_tvalid", 256'(axm_tvalid), 256'd1);
        chk("repack_pix0", 256'(axm_tdata[39:0]), 256'(pix0_exp));
        chk("repack_p3c3", 256'(axm_tdata[159:150]), 256'(p3c3_exp));
        chk("repack_tuser", 256'(axm_tuser), 256'd0);

        asi_data = '1;
        asi_sop  = 1'b1;
        tick();
        chk("mask_tdata", 256'(axm_tdata), 256'({BAXI{1'b1}}));
        chk("sop_tuser", 256'(axm_tuser), 256'h00001);
        chk("sop_tlast", 256'(axm_tlast), 256'd0);

        asi_data = pat;
        asi_sop  = 1'b0;
        asi_eop  = 1'b1;
        tick();
        chk("eop_tuser", 256'(axm_tuser), 256'h00002);
        chk("eop_tlast", 256'(axm_tlast), 256'd1);
        chk("eop_tdata", 256'(axm_tdata[39:0]), 256'(pix0_exp));

        asi_valid = 1'b0;
        asi_eop   = 1'b0;
        tick();
        chk("drain_tvalid", 256'(axm_tvalid), 256'd0);

        // Backpressure: three beats offered with the sink stalled.
        for (int i = 0; i < 16; i++) begin
            beat_a[i*16 +: 16] = 16'(16'h0100 + i);
            beat_b[i*16 +: 16] = 16'(16'h0200 + 3*i);
            beat_c[i*16 +: 16] = 16'(16'h0300 + 5*i);
        end
        axm_tready = 1'b0;
        asi_valid  = 1'b1;
        asi_data   = beat_a;
        tick();
        chk("bp_ready_after_a", 256'(asi_ready), 256'd1);
        asi_data = beat_b;
        tick();
        chk("bp_ready_full", 256'(asi_ready), 256'd0);
        asi_data = beat_c;
        tick();
        tick();
        chk("bp_ready_held", 256'(asi_ready), 256'd0);
        chk("bp_tvalid_held", 256'(axm_tvalid), 256'd1);
        chk("bp_tdata_held", 256'(axm_tdata), 256'(repack(beat_a)));
        axm_tready = 1'b1;
        asi_valid  = 1'b0;
        tick();
        chk("bp_drain_b", 256'(axm_tdata), 256'(repack(beat_b)));
        chk("bp_drain_tvalid", 256'(axm_tvalid), 256'd1);
        chk("bp_ready_back", 256'(asi_ready), 256'd1);
        tick();
        chk("bp_empty", 256'(axm_tvalid), 256'd0);

        // Random traffic against a scoreboard.
        sent   = 0;
        cycles = 0;
        while ((sent < 1000 || sb.size() != 0) && cycles < 20000) begin
            for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
            asi_data   = rnd;
            asi_sop    = 1'($urandom_range(0, 1));
            asi_eop    = 1'($urandom_range(0, 1));
            asi_valid  = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            axm_tready = ($urandom_range(0, 2) != 0);
            #1;
            acc = asi_valid & asi_ready;
            xfr = axm_tvalid & axm_tready;
            if (xfr) begin
                if (sb.size() == 0) begin
                    chk("stress_spurious", 256'd1, 256'd0);
                end else begin
                    front = sb.pop_front();
                    chk("stress_beat", 256'({axm_tdata, axm_tlast, axm_tuser}),
                        256'({front.data, front.eop, 18'd0, front.eop, front.sop}));
                end
            end
            if (acc) begin
                sb.push_back('{data: repack(rnd), eop: asi_eop, sop: asi_sop});
                sent++;
            end
            tick();
            cycles++;
        end
        chk("stress_sent", 256'(sent), 256'd1000);
        chk("stress_drained", 256'(sb.size()), 256'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
